// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, MRET and interrupts at
// write-back and sequences flush, CSR commit and PC redirect.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_pc_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic [2:0]  mie_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        csr_we_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic [1:0]  mstatus_op_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 4;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_TRAP = 2'b01;
  localparam logic [1:0] OP_MRET = 2'b10;

  localparam logic [CODE_W-1:0] CODE_MEI = 4'd11;
  localparam logic [CODE_W-1:0] CODE_MSI = 4'd3;
  localparam logic [CODE_W-1:0] CODE_MTI = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_COMMIT,
    S_REDIRECT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_is_mret;
  logic              w_is_mret_nxt;
  logic              r_stall;
  logic              r_flush;
  logic              w_flush_nxt;
  logic              r_csr_we;
  logic              w_csr_we_nxt;
  logic [1:0]        r_op;
  logic [1:0]        w_op_nxt;
  logic              r_redirect;
  logic              w_redirect_nxt;
  logic [XLEN-1:0]   r_redirect_pc;
  logic [XLEN-1:0]   w_redirect_pc_nxt;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   w_mcause_nxt;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   w_mepc_nxt;
  logic [XLEN-1:0]   r_mtval;
  logic [XLEN-1:0]   w_mtval_nxt;

  logic [2:0]        w_pend;
  logic              w_irq_req;
  logic [CODE_W-1:0] w_irq_code;
  logic [XLEN-1:0]   w_trap_base;
  logic [XLEN-1:0]   w_vec_off;
  logic [XLEN-1:0]   w_trap_target;
  logic              w_unused;

  // Enabled pending sources, bit order {MEI, MTI, MSI} matching mie_i
  assign w_pend    = {xint_meip_i, xint_mtip_i, xint_msip_i} & mie_i;
  assign w_irq_req = wb_valid_i & mstatus_mie_i & (|w_pend);

  always_comb begin
    w_irq_code = CODE_MTI;
    if (w_pend[2]) begin
      w_irq_code = CODE_MEI;
    end else if (w_pend[0]) begin
      w_irq_code = CODE_MSI;
    end
  end

  // Vector offset applies only to interrupts in vectored mode
  assign w_trap_base   = {mtvec_i[XLEN-1:2], 2'b00};
  assign w_vec_off     = (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && r_mcause[XLEN-1])
                         ? XLEN'({r_mcause[CODE_W-1:0], 2'b00}) : '0;
  assign w_trap_target = XLEN'(w_trap_base + w_vec_off);

  assign w_unused = ^mepc_i[1:0];

  always_comb begin
    w_state_nxt       = r_state;
    w_is_mret_nxt     = r_is_mret;
    w_flush_nxt       = 1'b0;
    w_csr_we_nxt      = 1'b0;
    w_op_nxt          = OP_NONE;
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    w_mcause_nxt      = r_mcause;
    w_mepc_nxt        = r_mepc;
    w_mtval_nxt       = r_mtval;
    unique case (r_state)
      S_IDLE: begin
        if (exc_valid_i) begin
          w_state_nxt   = S_FLUSH;
          w_flush_nxt   = 1'b1;
          w_is_mret_nxt = 1'b0;
          w_mcause_nxt  = XLEN'(exc_cause_i);
          w_mepc_nxt    = exc_pc_i;
          w_mtval_nxt   = exc_tval_i;
        end else if (mret_i) begin
          w_state_nxt   = S_FLUSH;
          w_flush_nxt   = 1'b1;
          w_is_mret_nxt = 1'b1;
        end else if (w_irq_req) begin
          w_state_nxt   = S_FLUSH;
          w_flush_nxt   = 1'b1;
          w_is_mret_nxt = 1'b0;
          w_mcause_nxt  = {1'b1, (XLEN-1)'(w_irq_code)};
          w_mepc_nxt    = XLEN'(wb_pc_i + 32'd4);
          w_mtval_nxt   = '0;
        end
      end
      S_FLUSH: begin
        if (r_is_mret) begin
          w_state_nxt       = S_REDIRECT;
          w_redirect_nxt    = 1'b1;
          w_op_nxt          = OP_MRET;
          w_redirect_pc_nxt = {mepc_i[XLEN-1:2], 2'b00};
        end else begin
          w_state_nxt  = S_COMMIT;
          w_csr_we_nxt = 1'b1;
          w_op_nxt     = OP_TRAP;
        end
      end
      S_COMMIT: begin
        w_state_nxt       = S_REDIRECT;
        w_redirect_nxt    = 1'b1;
        w_redirect_pc_nxt = w_trap_target;
      end
      S_REDIRECT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= S_IDLE;
      r_is_mret     <= 1'b0;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_csr_we      <= 1'b0;
      r_op          <= OP_NONE;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_mcause      <= '0;
      r_mepc        <= '0;
      r_mtval       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_is_mret     <= w_is_mret_nxt;
      r_stall       <= (w_state_nxt != S_IDLE);
      r_flush       <= w_flush_nxt;
      r_csr_we      <= w_csr_we_nxt;
      r_op          <= w_op_nxt;
      r_redirect    <= w_redirect_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_mcause      <= w_mcause_nxt;
      r_mepc        <= w_mepc_nxt;
      r_mtval       <= w_mtval_nxt;
    end
  end

  assign stall_o       = r_stall;
  assign flush_o       = r_flush;
  assign csr_we_o      = r_csr_we;
  assign mstatus_op_o  = r_op;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign mcause_o      = r_mcause;
  assign mepc_o        = r_mepc;
  assign mtval_o       = r_mtval;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// requests checked against a priority/sequence model of the trap rules.
module tb_trap_ctrl;

  logic        clk;
  logic        rst_i;
  logic        exc_valid_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_tval_i;
  logic        mret_i;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic        xint_meip_i;
  logic        xint_mtip_i;
  logic        xint_msip_i;
  logic [2:0]  mie_i;
  logic        mstatus_mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        stall_o;
  logic        flush_o;
  logic        csr_we_o;
  logic [31:0] mcause_o;
  logic [31:0] mepc_o;
  logic [31:0] mtval_o;
  logic [1:0]  mstatus_op_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  int checks;
  int failures;

  trap_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .exc_valid_i   (exc_valid_i),
    .exc_cause_i   (exc_cause_i),
    .exc_pc_i      (exc_pc_i),
    .exc_tval_i    (exc_tval_i),
    .mret_i        (mret_i),
    .wb_valid_i    (wb_valid_i),
    .wb_pc_i       (wb_pc_i),
    .xint_meip_i   (xint_meip_i),
    .xint_mtip_i   (xint_mtip_i),
    .xint_msip_i   (xint_msip_i),
    .mie_i         (mie_i),
    .mstatus_mie_i (mstatus_mie_i),
    .mtvec_i       (mtvec_i),
    .mepc_i        (mepc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .csr_we_o      (csr_we_o),
    .mcause_o      (mcause_o),
    .mepc_o        (mepc_o),
    .mtval_o       (mtval_o),
    .mstatus_op_o  (mstatus_op_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid_i   = 1'b0;
    exc_cause_i   = 4'd0;
    exc_pc_i      = 32'd0;
    exc_tval_i    = 32'd0;
    mret_i        = 1'b0;
    wb_valid_i    = 1'b0;
    wb_pc_i       = 32'd0;
    xint_meip_i   = 1'b0;
    xint_mtip_i   = 1'b0;
    xint_msip_i   = 1'b0;
    mie_i         = 3'd0;
    mstatus_mie_i = 1'b0;
  endtask

  // Random request traffic while busy; leaves mtvec_i and mepc_i untouched
  task automatic drive_junk();
    exc_valid_i   = 1'($urandom_range(1));
    exc_cause_i   = 4'(2 * $urandom_range(3));
    exc_pc_i      = $urandom;
    exc_tval_i    = $urandom;
    mret_i        = 1'($urandom_range(1));
    wb_valid_i    = 1'($urandom_range(1));
    wb_pc_i       = $urandom;
    xint_meip_i   = 1'($urandom_range(1));
    xint_mtip_i   = 1'($urandom_range(1));
    xint_msip_i   = 1'($urandom_range(1));
    mie_i         = 3'($urandom_range(7));
    mstatus_mie_i = 1'($urandom_range(1));
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    clear_inputs();
    mtvec_i = 32'h0; mepc_i = 32'h0;
    exc_valid_i = 1'b1; exc_pc_i = 32'h55; mret_i = 1'b1;
    tick(); tick();
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
    checks++; if (csr_we_o !== 1'b0) begin failures++; $display("FAIL reset_csr_we got=%b exp=0", csr_we_o); end
    checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect_o); end
    checks++; if (mstatus_op_o !== 2'b00) begin failures++; $display("FAIL reset_op got=%b exp=00", mstatus_op_o); end
    checks++; if (redirect_pc_o !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc_o); end
    checks++; if ({mcause_o, mepc_o, mtval_o} !== 96'h0) begin failures++; $display("FAIL reset_csrs got=%h/%h/%h exp=0", mcause_o, mepc_o, mtval_o); end
    clear_inputs();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  // Accepted on the first rising edge after reset release
  task automatic test_exception();
    exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h100; exc_tval_i = 32'h13;
    mtvec_i = 32'h200;
    tick();
    exc_valid_i = 1'b0;
    checks++; if (flush_o !== 1'b1 || stall_o !== 1'b1 || csr_we_o !== 1'b0) begin failures++; $display("FAIL exc_flush got=f%b s%b w%b exp=f1 s1 w0", flush_o, stall_o, csr_we_o); end
    tick();
    checks++; if (csr_we_o !== 1'b1 || mstatus_op_o !== 2'b01 || flush_o !== 1'b0) begin failures++; $display("FAIL exc_commit got=w%b op%b f%b exp=w1 op01 f0", csr_we_o, mstatus_op_o, flush_o); end
    checks++; if (mcause_o !== 32'h2 || mepc_o !== 32'h100 || mtval_o !== 32'h13) begin failures++; $display("FAIL exc_csrs got=%h/%h/%h exp=2/100/13", mcause_o, mepc_o, mtval_o); end
    tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200 || csr_we_o !== 1'b0 || mstatus_op_o !== 2'b00) begin failures++; $display("FAIL exc_redirect got=r%b pc=%h w%b op%b exp=r1 pc=200 w0 op00", redirect_o, redirect_pc_o, csr_we_o, mstatus_op_o); end
    tick();
    checks++; if (stall_o !== 1'b0 || redirect_o !== 1'b0) begin failures++; $display("FAIL exc_idle got=s%b r%b exp=0 0", stall_o, redirect_o); end
  endtask

  task automatic test_interrupt_vectored();
    xint_meip_i = 1'b1; xint_mtip_i = 1'b1; mie_i = 3'b111; mstatus_mie_i = 1'b1;
    wb_valid_i = 1'b1; wb_pc_i = 32'h40; mtvec_i = 32'h301;
    tick();
    clear_inputs();
    checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL irq_flush got=%b exp=1", flush_o); end
    tick();
    checks++; if (mcause_o !== 32'h8000000B || mepc_o !== 32'h44 || mtval_o !== 32'h0 || csr_we_o !== 1'b1) begin failures++; $display("FAIL irq_csrs got=%h/%h/%h w%b exp=8000000b/44/0 w1", mcause_o, mepc_o, mtval_o, csr_we_o); end
    tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h32C) begin failures++; $display("FAIL irq_redirect got=r%b pc=%h exp=r1 pc=32c", redirect_o, redirect_pc_o); end
    tick();
  endtask

  task automatic test_mret();
    int we_count;
    we_count = 0;
    mret_i = 1'b1; mepc_i = 32'h1236;
    tick();
    mret_i = 1'b0;
    if (csr_we_o) we_count++;
    checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL mret_flush got=%b exp=1", flush_o); end
    tick();
    if (csr_we_o) we_count++;
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1234 || mstatus_op_o !== 2'b10) begin failures++; $display("FAIL mret_redirect got=r%b pc=%h op%b exp=r1 pc=1234 op10", redirect_o, redirect_pc_o, mstatus_op_o); end
    checks++; if (mcause_o !== 32'h8000000B || mepc_o !== 32'h44) begin failures++; $display("FAIL mret_hold got=%h/%h exp=8000000b/44", mcause_o, mepc_o); end
    tick();
    if (csr_we_o) we_count++;
    checks++; if (stall_o !== 1'b0 || mstatus_op_o !== 2'b00 || we_count != 0) begin failures++; $display("FAIL mret_idle got=s%b op%b we_count=%0d exp=0 00 0", stall_o, mstatus_op_o, we_count); end
  endtask

  task automatic test_priority();
    exc_valid_i = 1'b1; exc_cause_i = 4'd4; exc_pc_i = 32'h500; exc_tval_i = 32'hDEAD;
    mret_i = 1'b1; mepc_i = 32'h900;
    xint_meip_i = 1'b1; mie_i = 3'b111; mstatus_mie_i = 1'b1; wb_valid_i = 1'b1; wb_pc_i = 32'h80;
    mtvec_i = 32'h301;
    tick();
    clear_inputs();
    tick();
    checks++; if (csr_we_o !== 1'b1 || mcause_o !== 32'h4 || mepc_o !== 32'h500 || mtval_o !== 32'hDEAD) begin failures++; $display("FAIL prio_commit got=w%b %h/%h/%h exp=w1 4/500/dead", csr_we_o, mcause_o, mepc_o, mtval_o); end
    tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h300) begin failures++; $display("FAIL prio_redirect got=r%b pc=%h exp=r1 pc=300", redirect_o, redirect_pc_o); end
    tick(); tick();
    checks++; if (redirect_o !== 1'b0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin failures++; $display("FAIL prio_no_mret got=r%b s%b f%b exp=0 0 0", redirect_o, stall_o, flush_o); end
  endtask

  task automatic test_ignore_busy();
    int n_we;
    int n_rd;
    n_we = 0; n_rd = 0;
    exc_valid_i = 1'b1; exc_cause_i = 4'd6; exc_pc_i = 32'h600; exc_tval_i = 32'h1; mtvec_i = 32'h400;
    tick();
    exc_cause_i = 4'd0; exc_pc_i = 32'h700; exc_tval_i = 32'h2;
    for (int i = 0; i < 6; i++) begin
      tick();
      exc_valid_i = 1'b0;
      if (csr_we_o) n_we++;
      if (redirect_o) n_rd++;
    end
    checks++; if (n_we != 1 || n_rd != 1) begin failures++; $display("FAIL busy_counts got=we%0d rd%0d exp=1 1", n_we, n_rd); end
    checks++; if (mepc_o !== 32'h600 || mcause_o !== 32'h6) begin failures++; $display("FAIL busy_csrs got=%h/%h exp=600/6", mepc_o, mcause_o); end
  endtask

  task automatic test_back_to_back();
    logic exp_f;
    exc_valid_i = 1'b1; exc_cause_i = 4'd0; exc_pc_i = 32'hA0; mtvec_i = 32'h800;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_f = ((k % 4) == 0);
      checks++; if (flush_o !== exp_f) begin failures++; $display("FAIL b2b_flush k=%0d got=%b exp=%b", k, flush_o, exp_f); end
    end
    exc_valid_i = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    int n_bad;
    n_bad = 0;
    exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h123; exc_tval_i = 32'h9; mtvec_i = 32'h200;
    tick();
    exc_valid_i = 1'b0;
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (csr_we_o !== 1'b0 || stall_o !== 1'b0 || mstatus_op_o !== 2'b00) begin failures++; $display("FAIL rstmid_strobes got=w%b s%b op%b exp=0 0 00", csr_we_o, stall_o, mstatus_op_o); end
    checks++; if ({mcause_o, mepc_o, mtval_o} !== 96'h0) begin failures++; $display("FAIL rstmid_csrs got=%h/%h/%h exp=0", mcause_o, mepc_o, mtval_o); end
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (redirect_o || csr_we_o || flush_o) n_bad++;
    end
    checks++; if (n_bad != 0) begin failures++; $display("FAIL rstmid_after got=%0d strobes exp=0", n_bad); end
  endtask

  // Model: priority exc > mret > enabled interrupt, MEI > MSI > MTI
  task automatic test_random();
    int          kind;
    logic [2:0]  pend;
    logic [3:0]  code;
    logic [31:0] m_cause, m_epc, m_tval;
    logic [31:0] e_cause, e_epc, e_tval, mepc_s, mt2, e_pc;
    m_cause = 32'h0; m_epc = 32'h0; m_tval = 32'h0;
    for (int it = 0; it < 150; it++) begin
      drive_junk();
      exc_valid_i = ($urandom_range(3) == 0);
      mret_i      = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) wb_pc_i = 32'hFFFF_FFFC;
      mtvec_i = $urandom; mtvec_i[1] = 1'b0;
      mepc_i = $urandom;
      mepc_s = mepc_i;
      pend = {xint_meip_i, xint_mtip_i, xint_msip_i} & mie_i;
      if (exc_valid_i) kind = 1;
      else if (mret_i) kind = 2;
      else if (wb_valid_i && mstatus_mie_i && (pend != 3'b000)) kind = 3;
      else kind = 0;
      code = pend[2] ? 4'd11 : (pend[0] ? 4'd3 : 4'd7);
      if (kind == 1) begin
        e_cause = {28'h0, exc_cause_i}; e_epc = exc_pc_i; e_tval = exc_tval_i;
      end else begin
        e_cause = 32'h8000_0000 + {28'h0, code}; e_epc = wb_pc_i + 32'd4; e_tval = 32'h0;
      end
      tick();
      if (kind == 0) begin
        checks++; if (stall_o !== 1'b0 || flush_o !== 1'b0) begin failures++; $display("FAIL rnd_idle it=%0d got=s%b f%b exp=0 0", it, stall_o, flush_o); end
        continue;
      end
      checks++; if (flush_o !== 1'b1 || stall_o !== 1'b1 || csr_we_o !== 1'b0 || redirect_o !== 1'b0) begin failures++; $display("FAIL rnd_flush it=%0d got=f%b s%b w%b r%b exp=1 1 0 0", it, flush_o, stall_o, csr_we_o, redirect_o); end
      drive_junk();
      tick();
      if (kind == 2) begin
        checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== (mepc_s & 32'hFFFF_FFFC) || mstatus_op_o !== 2'b10 || csr_we_o !== 1'b0) begin failures++; $display("FAIL rnd_mret it=%0d got=r%b pc=%h op%b w%b exp=r1 pc=%h op10 w0", it, redirect_o, redirect_pc_o, mstatus_op_o, csr_we_o, mepc_s & 32'hFFFF_FFFC); end
        checks++; if (mcause_o !== m_cause || mepc_o !== m_epc || mtval_o !== m_tval) begin failures++; $display("FAIL rnd_mret_hold it=%0d got=%h/%h/%h exp=%h/%h/%h", it, mcause_o, mepc_o, mtval_o, m_cause, m_epc, m_tval); end
        drive_junk();
        tick();
        checks++; if (stall_o !== 1'b0 || redirect_o !== 1'b0 || mstatus_op_o !== 2'b00) begin failures++; $display("FAIL rnd_mret_end it=%0d got=s%b r%b op%b exp=0 0 00", it, stall_o, redirect_o, mstatus_op_o); end
        continue;
      end
      m_cause = e_cause; m_epc = e_epc; m_tval = e_tval;
      checks++; if (csr_we_o !== 1'b1 || mstatus_op_o !== 2'b01 || flush_o !== 1'b0) begin failures++; $display("FAIL rnd_commit it=%0d got=w%b op%b f%b exp=1 01 0", it, csr_we_o, mstatus_op_o, flush_o); end
      checks++; if (mcause_o !== e_cause || mepc_o !== e_epc || mtval_o !== e_tval) begin failures++; $display("FAIL rnd_csrs it=%0d got=%h/%h/%h exp=%h/%h/%h", it, mcause_o, mepc_o, mtval_o, e_cause, e_epc, e_tval); end
      mt2 = $urandom; mt2[1] = 1'b0;
      mtvec_i = mt2;
      drive_junk();
      e_pc = (mt2 & 32'hFFFF_FFFC) + (((mt2 & 32'h3) == 32'h1 && kind == 3) ? 32'(code) * 32'd4 : 32'd0);
      tick();
      checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== e_pc || csr_we_o !== 1'b0) begin failures++; $display("FAIL rnd_redirect it=%0d got=r%b pc=%h w%b exp=r1 pc=%h w0", it, redirect_o, redirect_pc_o, csr_we_o, e_pc); end
      drive_junk();
      tick();
      checks++; if (stall_o !== 1'b0 || redirect_o !== 1'b0) begin failures++; $display("FAIL rnd_end it=%0d got=s%b r%b exp=0 0", it, stall_o, redirect_o); end
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_exception();
    test_interrupt_vectored();
    test_mret();
    test_priority();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
